ysyx_22050039_mem_arbiter: RTL and testbench

- Shares the single physical memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between the execute stage's fetch/load/store logic and the memory model.
- Grants one transaction at a time and registers the winning request onto the memory port.
- Routes the response back to the owner, with LS priority and an IF anti-starvation limit.

---
 rtl/ysyx_22050039_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_ysyx_22050039_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_mem_arbiter.sv
// Two-requester arbiter for the single memory port: load/store has priority,
// instruction fetch is guaranteed a grant after STARVE_MAX consecutive losses.
module ysyx_22050039_mem_arbiter #(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [XLEN-1:0] ls_addr,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]      mem_wmask_q, mem_wmask_d;
    logic            grant_if, grant_ls, resp_fire;

    // IF only overrides LS once it has lost STARVE_MAX arbitrations in a row.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == IDLE) begin
            if (if_req_valid && (!ls_req_valid || starve_cnt_q == STARVE_LIM)) begin
                grant_if = 1'b1;
            end else if (ls_req_valid) begin
                grant_ls = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        starve_cnt_d    = starve_cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_we_d        = mem_we_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        case (state_q)
            IDLE: begin
                if (grant_if || grant_ls) begin
                    state_d         = REQ;
                    owner_d         = grant_ls;
                    mem_req_valid_d = 1'b1;
                    if (grant_ls) begin
                        mem_addr_d  = ls_addr;
                        mem_we_d    = ls_we;
                        mem_wdata_d = ls_wdata;
                        mem_wmask_d = ls_we ? ls_wmask : 8'h00;
                    end else begin
                        mem_addr_d  = if_addr;
                        mem_we_d    = 1'b0;
                        mem_wdata_d = '0;
                        mem_wmask_d = 8'h00;
                    end
                    if (grant_if) begin
                        starve_cnt_d = '0;
                    end else if (if_req_valid && starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            starve_cnt_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= 8'h00;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            starve_cnt_q    <= starve_cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
        end
    end

    // Responses are only honoured after memory has taken the request.
    assign resp_fire     = (state_q == RESP) && mem_resp_valid;
    assign if_resp_valid = resp_fire && !owner_q;
    assign ls_resp_valid = resp_fire && owner_q;
    assign if_rdata      = mem_rdata;
    assign ls_rdata      = mem_we_q ? '0 : mem_rdata;

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_we        = mem_we_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Randomised bench for the memory arbiter: requester/memory stimulus plus a
// transaction-level reference model feeding a scoreboard checked by a monitor.
module tb_ysyx_22050039_mem_arbiter;
    localparam int XLEN       = 64;
    localparam int STARVE_MAX = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req_valid = 1'b0;
    logic            if_req_ready;
    logic [XLEN-1:0] if_addr = '0;
    logic            if_resp_valid;
    logic [XLEN-1:0] if_rdata;
    logic            ls_req_valid = 1'b0;
    logic            ls_req_ready;
    logic [XLEN-1:0] ls_addr = '0;
    logic            ls_we = 1'b0;
    logic [XLEN-1:0] ls_wdata = '0;
    logic [7:0]      ls_wmask = '0;
    logic            ls_resp_valid;
    logic [XLEN-1:0] ls_rdata;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_resp_valid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            busy;

    ysyx_22050039_mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          if_rdy, ls_rdy, mreq_v, busy, if_resp, ls_resp, chk_f, we;
        logic [63:0] addr, wdata;
        logic [7:0]  wmask;
    } exp_t;
    typedef struct {
        bit          owner;
        logic [63:0] rdata;
    } resp_t;

    exp_t  cyc_q[$];
    resp_t resp_q[$];
    bit    obs_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    pat[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reference model: one transaction in flight, tracked as granted / taken by memory.
    bit          out_txn = 0, mem_took = 0;
    bit          cur_owner = 0, cur_we = 0;
    logic [63:0] cur_addr = '0, cur_wdata = '0;
    logic [7:0]  cur_wmask = '0;
    int          starve = 0, stall = 0, stall_knob = 0;
    bit          if_hold = 0, ls_hold = 0, ls_w = 0;
    logic [63:0] if_a = '0, ls_a = '0, ls_d = '0;
    logic [7:0]  ls_m = '0;
    int          p_if = 0, p_ls = 0, p_rdy = 0, p_resp = 0, p_stray = 0;
    bit          drop_en = 0, fix_en = 0, log_en = 0;
    logic [63:0] fix_rdata = '0;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        exp_t e;
        bit   win_if, win_ls;
        @(posedge clk); #1;
        rst = 1'b0;
        if (!if_hold) begin
            if (chance(p_if)) begin if_hold = 1; if_a = rnd64(); end
        end else if (drop_en && chance(10)) if_hold = 0;
        else if (drop_en && chance(10)) if_a = rnd64();
        if (!ls_hold) begin
            if (chance(p_ls)) begin
                ls_hold = 1; ls_a = rnd64(); ls_w = 1'($urandom_range(1));
                ls_d = rnd64(); ls_m = 8'($urandom);
            end
        end else if (drop_en && chance(10)) ls_hold = 0;
        else if (drop_en && chance(10)) ls_a = rnd64();
        if_req_valid = if_hold; if_addr = if_a;
        ls_req_valid = ls_hold; ls_addr = ls_a; ls_we = ls_w; ls_wdata = ls_d; ls_wmask = ls_m;
        mem_rdata = fix_en ? fix_rdata : rnd64();
        if (out_txn && !mem_took && stall > 0) mem_req_ready = 1'b0;
        else mem_req_ready = chance(p_rdy);
        mem_resp_valid = (out_txn && mem_took) ? chance(p_resp) : chance(p_stray);

        e = '{default: 0};
        e.busy   = out_txn;
        e.mreq_v = out_txn && !mem_took;
        if (out_txn && !mem_took) begin
            e.chk_f = 1; e.addr = cur_addr; e.we = cur_we; e.wdata = cur_wdata; e.wmask = cur_wmask;
            if (stall > 0) stall--;
            else if (mem_req_ready) mem_took = 1;
        end else if (out_txn) begin
            if (mem_resp_valid) begin
                e.if_resp = !cur_owner; e.ls_resp = cur_owner;
                resp_q.push_back('{cur_owner, (cur_owner && cur_we) ? 64'h0 : mem_rdata});
                out_txn = 0; mem_took = 0;
            end
        end else begin
            win_ls = ls_hold && !(if_hold && starve == STARVE_MAX);
            win_if = if_hold && !win_ls;
            e.if_rdy = win_if; e.ls_rdy = win_ls;
            if (win_if || win_ls) begin
                if (win_if) starve = 0;
                else if (if_hold && starve < STARVE_MAX) starve++;
                cur_owner = win_ls;
                cur_addr  = win_ls ? ls_a : if_a;
                cur_we    = win_ls && ls_w;
                cur_wdata = win_ls ? ls_d : 64'h0;
                cur_wmask = (win_ls && ls_w) ? ls_m : 8'h00;
                out_txn = 1; mem_took = 0; stall = stall_knob;
                if (win_ls) ls_hold = 0; else if_hold = 0;
            end
        end
        cyc_q.push_back(e);
    endtask

    task automatic reset_step();
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        if_req_valid = 0; ls_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
        if_hold = 0; ls_hold = 0; out_txn = 0; mem_took = 0; starve = 0; stall = 0;
        resp_q.delete();
        e = '{default: 0};
        e.chk_f = 1;
        cyc_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        resp_t r;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("if_req_ready", 64'(if_req_ready), 64'(e.if_rdy));
            check("ls_req_ready", 64'(ls_req_ready), 64'(e.ls_rdy));
            check("mem_req_valid", 64'(mem_req_valid), 64'(e.mreq_v));
            check("busy", 64'(busy), 64'(e.busy));
            check("if_resp_valid", 64'(if_resp_valid), 64'(e.if_resp));
            check("ls_resp_valid", 64'(ls_resp_valid), 64'(e.ls_resp));
            if (e.chk_f) begin
                check("mem_addr", mem_addr, e.addr);
                check("mem_we", 64'(mem_we), 64'(e.we));
                check("mem_wdata", mem_wdata, e.wdata);
                check("mem_wmask", 64'(mem_wmask), 64'(e.wmask));
            end
            if (if_resp_valid || ls_resp_valid) begin
                if (resp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL resp_unexpected: if_resp=%0d ls_resp=%0d, want none", if_resp_valid, ls_resp_valid);
                end else begin
                    r = resp_q.pop_front();
                    check("resp_owner", 64'(ls_resp_valid), 64'(r.owner));
                    check("resp_rdata", r.owner ? ls_rdata : if_rdata, r.rdata);
                end
            end
            if (log_en && (if_req_ready || ls_req_ready)) obs_q.push_back(ls_req_ready);
        end
    end

    initial begin
        repeat (3) reset_step();

        // Lone fetch with a fast memory.
        fix_en = 1; fix_rdata = 64'h00100073_00000413; p_rdy = 100; p_resp = 100;
        if_hold = 1; if_a = 64'h80000000;
        repeat (4) step();
        fix_en = 0;

        // Simultaneous fetch and load: LS first, IF next; load mask must be dropped.
        if_hold = 1; if_a = 64'h80000004;
        ls_hold = 1; ls_a = 64'h80001000; ls_w = 0; ls_d = rnd64(); ls_m = 8'hA5;
        repeat (8) step();

        // Store held off by memory for three cycles.
        ls_hold = 1; ls_a = 64'h80002000; ls_w = 1; ls_d = 64'hDEADBEEF_CAFEF00D; ls_m = 8'hFF;
        stall_knob = 3;
        repeat (8) step();
        stall_knob = 0;

        // Both requesters continuously valid.
        p_if = 100; p_ls = 100; log_en = 1;
        repeat (60) step();
        log_en = 0; p_if = 0; p_ls = 0; if_hold = 0; ls_hold = 0;
        repeat (4) step();

        // Reset while waiting for a load response, then a stray response.
        ls_hold = 1; ls_a = 64'h80003000; ls_w = 0; ls_d = '0; ls_m = '0;
        p_resp = 0;
        repeat (3) step();
        reset_step();
        p_stray = 100;
        step();
        p_stray = 0;
        repeat (2) step();

        // Random traffic with stalls, stray responses and withdrawn requests.
        p_if = 40; p_ls = 40; p_rdy = 60; p_resp = 50; p_stray = 30; drop_en = 1;
        repeat (2000) step();
        p_if = 0; p_ls = 0; drop_en = 0; if_hold = 0; ls_hold = 0;
        p_rdy = 100; p_resp = 100; p_stray = 0;
        repeat (6) step();

        @(negedge clk); #1;
        if (obs_q.size() < 10) begin
            n_cmp++; n_bad++;
            $display("FAIL starve_grant_count: got %0d grants, want at least 10", obs_q.size());
        end else begin
            for (int i = 0; i < 10; i++) check("starve_grant_order", 64'(obs_q[i]), 64'(pat[i]));
        end
        check("resp_queue_left", 64'(resp_q.size()), 64'h0);
        check("cycle_queue_left", 64'(cyc_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
